// File: rtl/contador_ext_hi.sv
// Upper-count extension for the 4-bit contadorB counter: tracks carries/borrows
// and loads from the lower stage and presents a time-aligned composite count.
//
// state   | meaning
// ST_IDLE | out of reset, waiting for first load or enabled count; valid=0
// ST_RUN  | counting, upper follows rco_in/load_in from the lower stage
// ST_HOLD | enable low, upper frozen, lower-stage events ignored
module contador_ext_hi #(
  parameter int WIDTH_HI = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [WIDTH_HI-1:0]   D_hi,
  input  logic [3:0]            q_lo,
  input  logic                  rco_in,
  input  logic                  load_in,
  output logic [WIDTH_HI+3:0]   Q_ext,
  output logic                  rco_out,
  output logic                  load_out,
  output logic                  valid,
  output logic                  mode_chg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH_HI-1:0] ONE_HI = {{(WIDTH_HI-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [WIDTH_HI-1:0] upper_q, upper_d;
  logic [3:0]          q_lo_dly_q, q_lo_dly_d;
  logic [1:0]          mode_prev_q, mode_prev_d;
  logic                rco_out_q, rco_out_d;
  logic                load_out_q, load_out_d;
  logic                valid_q, valid_d;
  logic                mode_chg_q, mode_chg_d;
  logic                upd_en;

  always_comb begin
    state_d     = state_q;
    upper_d     = upper_q;
    rco_out_d   = 1'b0;
    load_out_d  = 1'b0;
    q_lo_dly_d  = q_lo;
    mode_prev_d = mode;

    // A load is still accepted while idle so the first lower-stage load seeds the upper count.
    upd_en = ((state_q == ST_RUN) && enable) || ((state_q == ST_IDLE) && load_in);

    if (upd_en) begin
      if (load_in) begin
        upper_d    = D_hi;
        load_out_d = 1'b1;
      end else if (rco_in) begin
        case (mode)
          2'b00: begin
            upper_d   = upper_q + ONE_HI;
            rco_out_d = &upper_q;
          end
          2'b01, 2'b10: begin
            upper_d   = upper_q - ONE_HI;
            rco_out_d = ~|upper_q;
          end
          default: ;
        endcase
      end
    end

    case (state_q)
      ST_IDLE: if (load_in || (enable && !rco_in)) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_HOLD;
      ST_HOLD: if (enable) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    valid_d    = valid_q | (state_d != ST_IDLE);
    mode_chg_d = (state_q == ST_RUN) && (mode != mode_prev_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      upper_q     <= '0;
      q_lo_dly_q  <= '0;
      mode_prev_q <= 2'b00;
      rco_out_q   <= 1'b0;
      load_out_q  <= 1'b0;
      valid_q     <= 1'b0;
      mode_chg_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      upper_q     <= upper_d;
      q_lo_dly_q  <= q_lo_dly_d;
      mode_prev_q <= mode_prev_d;
      rco_out_q   <= rco_out_d;
      load_out_q  <= load_out_d;
      valid_q     <= valid_d;
      mode_chg_q  <= mode_chg_d;
    end
  end

  assign Q_ext    = {upper_q, q_lo_dly_q};
  assign rco_out  = rco_out_q;
  assign load_out = load_out_q;
  assign valid    = valid_q;
  assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_contador_ext_hi.sv
// Bench for contador_ext_hi: directed vector table, reset corner sequence,
// then random stimulus against a behavioural model of the composite counter.
module tb_contador_ext_hi;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] D_hi;
  logic [3:0] q_lo;
  logic       rco_in;
  logic       load_in;
  logic [7:0] Q_ext;
  logic       rco_out, load_out, valid, mode_chg;

  int n_tests = 0;
  int n_fail  = 0;

  contador_ext_hi #(.WIDTH_HI(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D_hi(D_hi),
    .q_lo(q_lo), .rco_in(rco_in), .load_in(load_in), .Q_ext(Q_ext),
    .rco_out(rco_out), .load_out(load_out), .valid(valid), .mode_chg(mode_chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] md;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;
    logic       ld;
    logic [7:0] e_q;
    logic       e_rco;
    logic       e_ld;
    logic       e_vld;
    logic       e_mchg;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] md, input logic [3:0] d,
                       input logic [3:0] q, input logic rco, input logic ld);
    enable = en; mode = md; D_hi = d; q_lo = q; rco_in = rco; load_in = ld;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Model of the composite counter in plain arithmetic
  int m_upper, m_qlo, m_mprev;
  bit m_started, m_running;
  bit e_rco, e_ld, e_mchg;

  task automatic model_reset();
    m_upper = 0; m_qlo = 0; m_mprev = 0;
    m_started = 0; m_running = 0;
    e_rco = 0; e_ld = 0; e_mchg = 0;
  endtask

  task automatic model_edge();
    bit take;
    take   = (!m_started && load_in) || (m_started && m_running && enable);
    e_rco  = 0;
    e_ld   = 0;
    e_mchg = m_started && m_running && (int'(mode) != m_mprev);
    if (take) begin
      if (load_in) begin
        m_upper = int'(D_hi);
        e_ld    = 1;
      end else if (rco_in && mode == 2'b00) begin
        e_rco   = (m_upper == 15);
        m_upper = (m_upper + 1) % 16;
      end else if (rco_in && (mode == 2'b01 || mode == 2'b10)) begin
        e_rco   = (m_upper == 0);
        m_upper = (m_upper + 15) % 16;
      end
    end
    m_mprev = int'(mode);
    m_qlo   = int'(q_lo);
    if (!m_started) begin
      if (load_in || (enable && !rco_in)) begin
        m_started = 1;
        m_running = 1;
      end
    end else begin
      m_running = enable;
    end
  endtask

  initial begin
    // en md d q rco ld | Q rco ld vld mchg
    vec[0]  = '{1'b0, 2'd3, 4'hF, 4'hE, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[1]  = '{1'b1, 2'd0, 4'h0, 4'hF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[2]  = '{1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 2'd0, 4'h0, 4'h1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 2'd1, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[5]  = '{1'b1, 2'd1, 4'h0, 4'hF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 2'd1, 4'h0, 4'hE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 2'd2, 4'h0, 4'h1, 1'b0, 1'b0, 8'hF1, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[8]  = '{1'b1, 2'd2, 4'h0, 4'hE, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{1'b1, 2'd2, 4'h0, 4'hB, 1'b0, 1'b0, 8'hEB, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[10] = '{1'b1, 2'd3, 4'h3, 4'h7, 1'b1, 1'b1, 8'h37, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[11] = '{1'b1, 2'd3, 4'h3, 4'h7, 1'b1, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[12] = '{1'b0, 2'd0, 4'h0, 4'h7, 1'b1, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[13] = '{1'b0, 2'd0, 4'h9, 4'h7, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[14] = '{1'b1, 2'd0, 4'h0, 4'h8, 1'b1, 1'b0, 8'h38, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[15] = '{1'b1, 2'd0, 4'h0, 4'h9, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[16] = '{1'b1, 2'd1, 4'h0, 4'h8, 1'b0, 1'b0, 8'h38, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[17] = '{1'b1, 2'd1, 4'h0, 4'h7, 1'b0, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1, 1'b0};

    do_reset();
    chk("reset_q", 32'(Q_ext), 32'h0);
    chk("reset_flags", 32'({rco_out, load_out, valid, mode_chg}), 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].en, vec[i].md, vec[i].d, vec[i].q, vec[i].rco, vec[i].ld);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_q", i), 32'(Q_ext), 32'(vec[i].e_q));
      chk($sformatf("vec%0d_flags", i), 32'({rco_out, load_out, valid, mode_chg}),
          32'({vec[i].e_rco, vec[i].e_ld, vec[i].e_vld, vec[i].e_mchg}));
    end

    // Asynchronous reset between edges, then confirm the block is idle again
    do_reset();
    drive(1'b0, 2'b00, 4'h5, 4'h2, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_q", 32'(Q_ext), 32'h52);
    drive(1'b1, 2'b00, 4'h0, 4'h3, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_q", 32'(Q_ext), 32'h0);
    chk("async_rst_valid", 32'(valid), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("idle_en0_valid", 32'(valid), 32'h0);
    drive(1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("idle_rco_valid", 32'({Q_ext, rco_out, valid}), 32'h000);
    drive(1'b1, 2'b00, 4'h0, 4'h4, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("idle_exit_valid", 32'({Q_ext, valid}), 32'h009);

    // Random stimulus against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
            4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("rand%0d", c), 32'({Q_ext, rco_out, load_out, valid, mode_chg}),
          32'({4'(m_upper), 4'(m_qlo), e_rco, e_ld, m_started, e_mchg}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_ext_hi.md
Name: contador_ext_hi

Overview:
- Downstream extension stage for the 4-bit contadorB counter. Consumes its Q, rco and load outputs.
- Maintains an upper count nibble-group, so the pair behaves as a single (4+WIDTH_HI)-bit counter.
- Produces a time-aligned composite count, a cascaded rco_out, load_out and status flags for the next stage or a scoreboard.

Parameters:
- WIDTH_HI, 4, width of the upper count register. Composite width is 4+WIDTH_HI.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  same enable driven to the lower counter
- mode  input  2  same mode driven to the lower counter: 00 up+1, 01 down-1, 10 down-3, 11 load D
- D_hi  input  WIDTH_HI  upper load value, captured on load
- q_lo  input  4  Q from lower counter
- rco_in  input  1  rco from lower counter, one-cycle pulse on wrap
- load_in  input  1  load from lower counter, high in the cycle its Q takes D
- Q_ext  output  4+WIDTH_HI  composite count {upper, q_lo delayed}
- rco_out  output  1  cascaded ripple carry/borrow
- load_out  output  1  composite load indication
- valid  output  1  Q_ext is meaningful
- mode_chg  output  1  one-cycle pulse when mode changes while counting

Behaviour:
- Reset (reset=0, async): upper=0, q_lo_d=0, Q_ext=0, rco_out=0, load_out=0, valid=0, mode_chg=0, mode_prev=00, state=ST_IDLE.
- Alignment: lower rco_in/load_in arrive registered in the same cycle as the wrapped or loaded q_lo. Upper updates on the following edge. q_lo is delayed one register (q_lo_d), so Q_ext = {upper, q_lo_d} is self-consistent. Latency from lower-counter event to Q_ext: 1 cycle.
- States:
  - ST_IDLE: valid=0. Go to ST_RUN on first load_in=1 or enable=1 with rco_in=0.
  - ST_RUN: enable=1. Go to ST_HOLD when enable=0.
  - ST_HOLD: upper frozen, rco_out=0. Back to ST_RUN when enable=1.
  - reset=0 from any state → ST_IDLE.
- valid=1 from the cycle after leaving ST_IDLE. Stays high until reset.
- Upper update priority, evaluated each edge in ST_RUN:
  1. load_in=1: upper<=D_hi, load_out<=1, rco_out<=0. Load wins over a simultaneous rco_in.
  2. rco_in=1, mode=00: upper<=upper+1, modulo 2^WIDTH_HI.
  3. rco_in=1, mode=01 or 10: upper<=upper-1, modulo 2^WIDTH_HI.
  4. Otherwise: hold.
- load_out and rco_out are single-cycle pulses, registered, aligned with the Q_ext update.
- rco_out=1 when an rco_in increment takes upper from all-ones to 0 (mode 00), or a decrement takes upper from 0 to all-ones (mode 01/10).
- rco_in with mode=11 and load_in=0 is a protocol violation. Upper holds, no rco_out.
- mode_chg=1 for one cycle when mode!=mode_prev while in ST_RUN. mode_prev updates every cycle.
- rco_in or load_in while enable=0: ignored, except that load_in is still honoured in ST_IDLE.
- Arithmetic is unsigned wrap. No saturation, no sticky overflow.

Test Plan:
- Reset mid-count: upper=0x5, assert reset=0 asynchronously between edges → Q_ext=0, valid=0 immediately, state ST_IDLE after release.
- Mode 00 cascade: load D_hi=0xF, lower loads 0xE, enable up → one cycle after the lower wrap, Q_ext goes 0xFF→0x00 and rco_out pulses once.
- Mode 01 borrow: upper=0x0, lower wraps 0→F with rco_in → upper=0xF, Q_ext=0xFF, rco_out=1 for exactly one cycle.
- Mode 10 down-3: lower 0x1 → 0xE with rco_in → upper decrements by 1 only, Q_ext consistent with 1-cycle latency.
- Simultaneous load_in and rco_in with D_hi=0x3 → upper=0x3, load_out=1, rco_out=0.
- Enable low (ST_HOLD) with spurious rco_in → upper unchanged. Mode switch 00→01 while running → mode_chg single pulse.
